// File: rtl/hci_bank_responder.sv
// TCDM bank target for hci_core_intf: 1-cycle SRAM access with credit-gated grant
// and a small response FIFO that absorbs r_ready backpressure.
module hci_bank_responder #(
  parameter int unsigned AW                   = 32,
  parameter int unsigned DW                   = 32,
  parameter int unsigned IW                   = 8,
  parameter int unsigned USE_ECC              = 0,
  parameter int unsigned FILTER_WRITE_R_VALID = 0,
  parameter int unsigned RESP_DEPTH           = 2,
  localparam int unsigned BW                  = DW / 8,
  localparam int unsigned EW                  = (USE_ECC != 0) ? 7 : 1
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               clear_i,
  input  logic               tgt_req_i,
  output logic               tgt_gnt_o,
  input  logic [AW-1:0]      tgt_add_i,
  input  logic               tgt_wen_i,
  input  logic [BW-1:0]      tgt_be_i,
  input  logic [DW-1:0]      tgt_data_i,
  input  logic [EW-1:0]      tgt_ecc_i,
  input  logic [IW-1:0]      tgt_id_i,
  output logic               tgt_r_valid_o,
  input  logic               tgt_r_ready_i,
  output logic [DW-1:0]      tgt_r_data_o,
  output logic [EW-1:0]      tgt_r_ecc_o,
  output logic [IW-1:0]      tgt_r_id_o,
  output logic               mem_req_o,
  output logic               mem_we_o,
  output logic [AW-3:0]      mem_addr_o,
  output logic [BW-1:0]      mem_be_o,
  output logic [DW+EW-1:0]   mem_wdata_o,
  input  logic [DW+EW-1:0]   mem_rdata_i
);

  localparam int unsigned PW = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam int unsigned CW = $clog2(RESP_DEPTH + 1);

  typedef struct packed {
    logic [DW-1:0] data;
    logic [EW-1:0] ecc;
    logic [IW-1:0] id;
  } resp_t;

  logic          is_write_c;
  logic          needs_credit_c;
  logic          credit_ok_c;
  logic          gnt_c;
  logic          accept_c;

  logic          inflight_q, inflight_d;
  logic          inflight_we_q, inflight_we_d;
  logic [IW-1:0] inflight_id_q, inflight_id_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  resp_t         fifo_q [RESP_DEPTH];
  resp_t         fifo_d [RESP_DEPTH];

  resp_t         new_resp_c;
  resp_t         head_c;
  logic          r_valid_c;
  logic          push_c;
  logic          fifo_pop_c;
  logic          unused_c;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(RESP_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Request side: writes without a response need no credit when filtered.
  always_comb begin
    is_write_c     = ~tgt_wen_i & (|tgt_be_i);
    needs_credit_c = ~(is_write_c & (FILTER_WRITE_R_VALID != 0));
    credit_ok_c    = ((CW+1)'(cnt_q) + (CW+1)'(inflight_q)) < (CW+1)'(RESP_DEPTH);
    gnt_c          = tgt_req_i & ~clear_i & (credit_ok_c | ~needs_credit_c);
    accept_c       = tgt_req_i & gnt_c;
  end

  assign tgt_gnt_o   = gnt_c;
  assign mem_req_o   = accept_c;
  assign mem_we_o    = accept_c & is_write_c;
  assign mem_addr_o  = tgt_add_i[AW-1:2];
  assign mem_be_o    = tgt_be_i;
  assign mem_wdata_o = {tgt_data_i, tgt_ecc_i};
  assign unused_c    = ^tgt_add_i[1:0];

  // Response side: FIFO head has priority, otherwise the SRAM word bypasses.
  always_comb begin
    new_resp_c    = '0;
    new_resp_c.id = inflight_id_q;
    if (!inflight_we_q) begin
      new_resp_c.data = mem_rdata_i[DW+EW-1:EW];
      if (USE_ECC != 0) new_resp_c.ecc = mem_rdata_i[EW-1:0];
    end
    head_c     = (cnt_q != '0) ? fifo_q[rd_ptr_q] : new_resp_c;
    r_valid_c  = (cnt_q != '0) | inflight_q;
    fifo_pop_c = (cnt_q != '0) & tgt_r_ready_i;
    push_c     = inflight_q & ~((cnt_q == '0) & tgt_r_ready_i);
  end

  always_comb begin
    tgt_r_valid_o = r_valid_c;
    tgt_r_data_o  = '0;
    tgt_r_ecc_o   = '0;
    tgt_r_id_o    = '0;
    if (r_valid_c) begin
      tgt_r_data_o = head_c.data;
      tgt_r_ecc_o  = head_c.ecc;
      tgt_r_id_o   = head_c.id;
    end
  end

  // Next state for the inflight slot and the FIFO; clear overrides everything.
  always_comb begin
    inflight_d    = accept_c & needs_credit_c;
    inflight_we_d = inflight_we_q;
    inflight_id_d = inflight_id_q;
    cnt_d         = cnt_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    fifo_d        = fifo_q;

    if (accept_c) begin
      inflight_we_d = is_write_c;
      inflight_id_d = tgt_id_i;
    end
    if (push_c) begin
      fifo_d[wr_ptr_q] = new_resp_c;
      wr_ptr_d         = ptr_inc(wr_ptr_q);
    end
    if (fifo_pop_c) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    cnt_d = cnt_q + CW'(push_c) - CW'(fifo_pop_c);

    if (clear_i) begin
      inflight_d = 1'b0;
      cnt_d      = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      inflight_q    <= 1'b0;
      inflight_we_q <= 1'b0;
      inflight_id_q <= '0;
      cnt_q         <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      for (int i = 0; i < int'(RESP_DEPTH); i++) fifo_q[i] <= '0;
    end else begin
      inflight_q    <= inflight_d;
      inflight_we_q <= inflight_we_d;
      inflight_id_q <= inflight_id_d;
      cnt_q         <= cnt_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      fifo_q        <= fifo_d;
    end
  end

endmodule

// File: tb/tb_hci_bank_responder.sv
// Bench for hci_bank_responder: default instance checked by a response scoreboard,
// plus a write-filtering ECC instance checked directly.
module tb_hci_bank_responder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- instance A: FILTER=0, USE_ECC=0 ----------------
  logic        clear_a = 0, req_a = 0, wen_a = 1, r_ready_a = 0;
  logic        gnt_a, r_valid_a, mem_req_a, mem_we_a;
  logic [31:0] add_a = 0, wdata_a = 0, r_data_a;
  logic [3:0]  be_a = 0, mem_be_a;
  logic [0:0]  ecc_a = 0, r_ecc_a;
  logic [7:0]  id_a = 0, r_id_a;
  logic [29:0] mem_addr_a;
  logic [32:0] mem_wdata_a, mem_rdata_a = '0;
  logic [32:0] mem_a [256];

  hci_bank_responder u_dut_a (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear_a),
    .tgt_req_i(req_a), .tgt_gnt_o(gnt_a), .tgt_add_i(add_a), .tgt_wen_i(wen_a),
    .tgt_be_i(be_a), .tgt_data_i(wdata_a), .tgt_ecc_i(ecc_a), .tgt_id_i(id_a),
    .tgt_r_valid_o(r_valid_a), .tgt_r_ready_i(r_ready_a), .tgt_r_data_o(r_data_a),
    .tgt_r_ecc_o(r_ecc_a), .tgt_r_id_o(r_id_a),
    .mem_req_o(mem_req_a), .mem_we_o(mem_we_a), .mem_addr_o(mem_addr_a),
    .mem_be_o(mem_be_a), .mem_wdata_o(mem_wdata_a), .mem_rdata_i(mem_rdata_a)
  );

  always @(posedge clk) begin
    if (mem_req_a) begin
      if (mem_we_a) begin
        for (int b = 0; b < 4; b++)
          if (mem_be_a[b]) mem_a[mem_addr_a[7:0]][1+8*b +: 8] <= mem_wdata_a[1+8*b +: 8];
        mem_a[mem_addr_a[7:0]][0] <= mem_wdata_a[0];
      end else begin
        mem_rdata_a <= mem_a[mem_addr_a[7:0]];
      end
    end
  end

  // ---------------- instance B: FILTER=1, USE_ECC=1 ----------------
  logic        req_b = 0, wen_b = 1, r_ready_b = 0;
  logic        gnt_b, r_valid_b, mem_req_b, mem_we_b;
  logic [31:0] add_b = 0, wdata_b = 0, r_data_b;
  logic [3:0]  be_b = 0, mem_be_b;
  logic [6:0]  ecc_b = 0, r_ecc_b;
  logic [7:0]  id_b = 0, r_id_b;
  logic [29:0] mem_addr_b;
  logic [38:0] mem_wdata_b, mem_rdata_b = '0;
  logic [38:0] mem_b [256];

  hci_bank_responder #(.USE_ECC(1), .FILTER_WRITE_R_VALID(1)) u_dut_b (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(1'b0),
    .tgt_req_i(req_b), .tgt_gnt_o(gnt_b), .tgt_add_i(add_b), .tgt_wen_i(wen_b),
    .tgt_be_i(be_b), .tgt_data_i(wdata_b), .tgt_ecc_i(ecc_b), .tgt_id_i(id_b),
    .tgt_r_valid_o(r_valid_b), .tgt_r_ready_i(r_ready_b), .tgt_r_data_o(r_data_b),
    .tgt_r_ecc_o(r_ecc_b), .tgt_r_id_o(r_id_b),
    .mem_req_o(mem_req_b), .mem_we_o(mem_we_b), .mem_addr_o(mem_addr_b),
    .mem_be_o(mem_be_b), .mem_wdata_o(mem_wdata_b), .mem_rdata_i(mem_rdata_b)
  );

  always @(posedge clk) begin
    if (mem_req_b) begin
      if (mem_we_b) begin
        for (int b = 0; b < 4; b++)
          if (mem_be_b[b]) mem_b[mem_addr_b[7:0]][7+8*b +: 8] <= mem_wdata_b[7+8*b +: 8];
        mem_b[mem_addr_b[7:0]][6:0] <= mem_wdata_b[6:0];
      end else begin
        mem_rdata_b <= mem_b[mem_addr_b[7:0]];
      end
    end
  end

  // ---------------- scoreboard for instance A ----------------
  typedef struct {
    logic [31:0] data;
    logic [7:0]  id;
  } exp_t;
  exp_t exp_q [$];
  exp_t mon_e;

  task automatic expect_a(input logic [31:0] data, input logic [7:0] id);
    exp_t e;
    e.data = data;
    e.id   = id;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (rst_n && r_valid_a && r_ready_a) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_resp", 64'(r_id_a), 64'hFFFF);
      end else begin
        mon_e = exp_q.pop_front();
        chk("resp_data", 64'(r_data_a), 64'(mon_e.data));
        chk("resp_id", 64'(r_id_a), 64'(mon_e.id));
      end
    end
  end

  // Present a request until granted (bounded), sampling gnt on the falling edge.
  task automatic issue_a(input logic wen, input logic [31:0] add, input logic [3:0] be,
                         input logic [31:0] data, input logic [7:0] id,
                         output int waits, output logic we_seen);
    req_a = 1'b1; wen_a = wen; add_a = add; be_a = be; wdata_a = data; id_a = id;
    waits = 0; we_seen = 1'b0;
    @(negedge clk);
    while (!gnt_a && waits < 50) begin
      waits++;
      @(negedge clk);
    end
    if (!gnt_a) chk("issue_a_timeout", 64'(waits), 64'(0));
    else we_seen = mem_we_a;
    @(posedge clk); #1;
    req_a = 1'b0;
  endtask

  task automatic issue_b(input logic wen, input logic [31:0] add, input logic [3:0] be,
                         input logic [31:0] data, input logic [6:0] ecc, input logic [7:0] id,
                         output int waits);
    req_b = 1'b1; wen_b = wen; add_b = add; be_b = be; wdata_b = data; ecc_b = ecc; id_b = id;
    waits = 0;
    @(negedge clk);
    while (!gnt_b && waits < 50) begin
      waits++;
      @(negedge clk);
    end
    if (!gnt_b) chk("issue_b_timeout", 64'(waits), 64'(0));
    @(posedge clk); #1;
    req_b = 1'b0;
  endtask

  task automatic drain_a();
    int n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("drain_a", 64'(exp_q.size()), 64'(0));
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    int   w;
    logic we;

    // Reset state and combinational grant
    #1;
    chk("rst_r_valid", 64'(r_valid_a), 64'(0));
    chk("rst_r_data", 64'(r_data_a), 64'(0));
    chk("rst_r_id", 64'(r_id_a), 64'(0));
    #11 rst_n = 1'b1;
    @(posedge clk); #1;
    req_a = 1'b1; wen_a = 1'b1; be_a = 4'h0; #1;
    chk("gnt_follows_req", 64'(gnt_a), 64'(1));
    chk("memreq_follows_req", 64'(mem_req_a), 64'(1));
    req_a = 1'b0; #1;
    chk("gnt_drops", 64'(gnt_a), 64'(0));
    @(posedge clk); #1;

    // 1: write then read back, write response carries zero data
    r_ready_a = 1'b1;
    expect_a(32'h0, 8'd3);
    issue_a(1'b0, 32'h10, 4'hF, 32'hDEADBEEF, 8'd3, w, we);
    chk("t1_write_we", 64'(we), 64'(1));
    expect_a(32'hDEADBEEF, 8'd4);
    issue_a(1'b1, 32'h10, 4'hF, 32'h0, 8'd4, w, we);
    chk("t1_read_we", 64'(we), 64'(0));
    drain_a();

    // 2: preload 8 words, then 8 back-to-back reads with no stall
    for (int i = 0; i < 8; i++) begin
      expect_a(32'h0, 8'(100 + i));
      issue_a(1'b0, 32'h100 + 32'(4 * i), 4'hF, 32'hA5A50000 + 32'(i), 8'(100 + i), w, we);
    end
    drain_a();
    for (int i = 0; i < 8; i++) begin
      expect_a(32'hA5A50000 + 32'(i), 8'(10 + i));
      issue_a(1'b1, 32'h100 + 32'(4 * i), 4'hF, 32'h0, 8'(10 + i), w, we);
      chk("t2_no_wait", 64'(w), 64'(0));
      if (i > 0) chk("t2_rvalid_lat1", 64'(r_valid_a), 64'(1));
    end
    drain_a();

    // 3: backpressure holds two credits, then drains in order
    r_ready_a = 1'b0;
    fork
      begin
        for (int i = 0; i < 4; i++) begin
          expect_a(32'hA5A50000 + 32'(i), 8'(20 + i));
          issue_a(1'b1, 32'h100 + 32'(4 * i), 4'hF, 32'h0, 8'(20 + i), w, we);
        end
      end
      begin
        repeat (4) @(negedge clk);
        chk("t3_gnt_blocked", 64'(gnt_a), 64'(0));
        chk("t3_head_id", 64'(r_id_a), 64'(20));
        @(negedge clk);
        chk("t3_still_blocked", 64'(gnt_a), 64'(0));
        chk("t3_head_stable", 64'(r_data_a), 64'(32'hA5A50000));
        chk("t3_head_id_stable", 64'(r_id_a), 64'(20));
        @(posedge clk); #1;
        r_ready_a = 1'b1;
      end
    join
    drain_a();

    // 5: wen=0 with be=0 is a read and must not modify memory
    expect_a(32'h0, 8'd29);
    issue_a(1'b0, 32'h20, 4'hF, 32'h12345678, 8'd29, w, we);
    expect_a(32'h12345678, 8'd30);
    issue_a(1'b0, 32'h20, 4'h0, 32'hFFFFFFFF, 8'd30, w, we);
    chk("t5_no_we", 64'(we), 64'(0));
    expect_a(32'h12345678, 8'd31);
    issue_a(1'b1, 32'h20, 4'hF, 32'h0, 8'd31, w, we);
    drain_a();

    // 6a: clear with two pending responses
    r_ready_a = 1'b0;
    expect_a(32'hA5A50000, 8'd40);
    issue_a(1'b1, 32'h100, 4'hF, 32'h0, 8'd40, w, we);
    expect_a(32'hA5A50001, 8'd41);
    issue_a(1'b1, 32'h104, 4'hF, 32'h0, 8'd41, w, we);
    clear_a = 1'b1; req_a = 1'b1; wen_a = 1'b1; add_a = 32'h100; id_a = 8'd99; #1;
    chk("t6_gnt_in_clear", 64'(gnt_a), 64'(0));
    chk("t6_memreq_in_clear", 64'(mem_req_a), 64'(0));
    @(negedge clk);
    chk("t6_pending_before", 64'(r_valid_a), 64'(1));
    @(posedge clk); #1;
    clear_a = 1'b0; req_a = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("t6_clear_rvalid", 64'(r_valid_a), 64'(0));
    @(posedge clk); #1;

    // 6b: async reset in the middle of a backpressured burst
    expect_a(32'hA5A50002, 8'd50);
    issue_a(1'b1, 32'h108, 4'hF, 32'h0, 8'd50, w, we);
    expect_a(32'hA5A50003, 8'd51);
    issue_a(1'b1, 32'h10C, 4'hF, 32'h0, 8'd51, w, we);
    rst_n = 1'b0; #1;
    chk("t6_rst_rvalid", 64'(r_valid_a), 64'(0));
    chk("t6_rst_rdata", 64'(r_data_a), 64'(0));
    chk("t6_rst_rid", 64'(r_id_a), 64'(0));
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    r_ready_a = 1'b1;
    expect_a(32'hA5A50004, 8'd52);
    issue_a(1'b1, 32'h110, 4'hF, 32'h0, 8'd52, w, we);
    drain_a();

    // 4: filtered writes need no credit and never raise r_valid
    r_ready_b = 1'b0;
    for (int i = 0; i < 4; i++) begin
      issue_b(1'b0, 32'(4 * i), 4'hF, 32'hC0DE0000 + 32'(i), 7'h11 + 7'(i), 8'(60 + i), w);
      chk("t4_no_wait", 64'(w), 64'(0));
      chk("t4_no_rvalid", 64'(r_valid_b), 64'(0));
    end
    repeat (2) @(negedge clk);
    chk("t4_quiet", 64'(r_valid_b), 64'(0));
    @(posedge clk); #1;
    r_ready_b = 1'b1;
    issue_b(1'b1, 32'h8, 4'hF, 32'h0, 7'h0, 8'd70, w);
    @(negedge clk);
    chk("t4_read_valid", 64'(r_valid_b), 64'(1));
    chk("t4_read_data", 64'(r_data_b), 64'(32'hC0DE0002));
    chk("t4_read_ecc", 64'(r_ecc_b), 64'(7'h13));
    chk("t4_read_id", 64'(r_id_b), 64'(70));
    @(posedge clk); #1;

    chk("final_queue_empty", 64'(exp_q.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
